mac_reg_bus_master: RTL

- Bridges the MAC configuration sequencer's simple command interface to the MAC IP's Avalon-MM control slave.
- Upstream side: wr_en / rd_en / addr / wdata in; rdy / rdata / rdata_vld back.
- Downstream side: av_address / av_write / av_read / av_writedata out; av_waitrequest / av_readdata in.
- Handles one transaction at a time, with waitrequest stalling and a timeout abort so a dead slave cannot hang configuration.

---
 rtl/mac_reg_bus_master.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mac_reg_bus_master.sv
// Single-outstanding bridge from the MAC config sequencer command port to the
// MAC Avalon-MM control slave, with waitrequest stalling and a stall timeout.
//
// state | meaning
// IDLE  | no transfer in flight, rdy high
// WR    | av_write asserted, waiting for av_waitrequest low
// RD    | av_read asserted, waiting for av_waitrequest low
module mac_reg_bus_master #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdy,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_vld,
  output logic [ADDR_W-1:0] av_address,
  output logic              av_write,
  output logic              av_read,
  output logic [DATA_W-1:0] av_writedata,
  input  logic              av_waitrequest,
  input  logic [DATA_W-1:0] av_readdata,
  output logic              timeout_err,
  output logic              cmd_err
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  localparam bit            TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [TO_W-1:0]   stall_cnt, stall_cnt_nxt;
  logic [DATA_W-1:0] rdata_nxt, av_writedata_nxt;
  logic [ADDR_W-1:0] av_address_nxt;
  logic              rdata_vld_nxt, av_write_nxt, av_read_nxt;
  logic              timeout_err_nxt, cmd_err_nxt;

  assign rdy = (state == IDLE) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      stall_cnt    <= '0;
      rdata        <= '0;
      rdata_vld    <= 1'b0;
      av_address   <= '0;
      av_write     <= 1'b0;
      av_read      <= 1'b0;
      av_writedata <= '0;
      timeout_err  <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      stall_cnt    <= stall_cnt_nxt;
      rdata        <= rdata_nxt;
      rdata_vld    <= rdata_vld_nxt;
      av_address   <= av_address_nxt;
      av_write     <= av_write_nxt;
      av_read      <= av_read_nxt;
      av_writedata <= av_writedata_nxt;
      timeout_err  <= timeout_err_nxt;
      cmd_err      <= cmd_err_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    stall_cnt_nxt    = stall_cnt;
    rdata_nxt        = rdata;
    rdata_vld_nxt    = 1'b0;
    av_address_nxt   = av_address;
    av_write_nxt     = av_write;
    av_read_nxt      = av_read;
    av_writedata_nxt = av_writedata;
    timeout_err_nxt  = 1'b0;
    cmd_err_nxt      = 1'b0;

    unique case (state)
      IDLE: begin
        // write wins a collision; the read is dropped and flagged
        if (wr_en) begin
          av_address_nxt   = addr;
          av_writedata_nxt = wdata;
          av_write_nxt     = 1'b1;
          stall_cnt_nxt    = '0;
          cmd_err_nxt      = rd_en;
          state_nxt        = WR;
        end else if (rd_en) begin
          av_address_nxt = addr;
          av_read_nxt    = 1'b1;
          stall_cnt_nxt  = '0;
          state_nxt      = RD;
        end
      end
      WR, RD: begin
        if (!av_waitrequest) begin
          av_write_nxt = 1'b0;
          av_read_nxt  = 1'b0;
          state_nxt    = IDLE;
          if (state == RD) begin
            rdata_nxt     = av_readdata;
            rdata_vld_nxt = 1'b1;
          end
        end else if (TO_EN && (stall_cnt == TO_LAST)) begin
          av_write_nxt    = 1'b0;
          av_read_nxt     = 1'b0;
          timeout_err_nxt = 1'b1;
          state_nxt       = IDLE;
        end else if (stall_cnt != '1) begin
          stall_cnt_nxt = stall_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
